// File: rtl/mdu_pkg.sv
// Shared definitions for the E-stage multiply/divide unit: MD opcodes,
// FSM state type and default latencies.
package mdu_pkg;

  localparam logic [2:0] MD_NONE  = 3'd0;
  localparam logic [2:0] MD_MULT  = 3'd1;
  localparam logic [2:0] MD_MULTU = 3'd2;
  localparam logic [2:0] MD_DIV   = 3'd3;
  localparam logic [2:0] MD_DIVU  = 3'd4;
  localparam logic [2:0] MD_MTHI  = 3'd5;
  localparam logic [2:0] MD_MTLO  = 3'd6;

  localparam int DEF_MULT_CYCLES = 5;
  localparam int DEF_DIV_CYCLES  = 10;

  typedef enum logic {
    ST_IDLE = 1'b0,
    ST_RUN  = 1'b1
  } mdu_state_e;

  function automatic int max2(input int a, input int b);
    return (a > b) ? a : b;
  endfunction

endpackage

// File: rtl/e_mdu.sv
// E-stage multiply/divide unit: computes at start, then models latency with a
// down-counter before committing into the architectural HI/LO registers.
module e_mdu
  import mdu_pkg::*;
#(
  parameter int MULT_CYCLES = DEF_MULT_CYCLES,
  parameter int DIV_CYCLES  = DEF_DIV_CYCLES
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [2:0]  E_md_op,
  input  logic        E_start,
  input  logic [31:0] E_data1,
  input  logic [31:0] E_data2,
  output logic        E_busy,
  output logic [31:0] E_HI,
  output logic [31:0] E_LO
);

  localparam int CW = $clog2(max2(MULT_CYCLES, DIV_CYCLES)) + 1;

  mdu_state_e    state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [31:0]   hi_q, hi_d, lo_q, lo_d;
  logic [31:0]   hi_tmp_q, hi_tmp_d, lo_tmp_q, lo_tmp_d;
  logic          dz_q, dz_d;

  logic [63:0] prod_s, prod_u;
  logic        is_sdiv, a_neg, b_neg;
  logic [31:0] abs_a, abs_b, divisor, q_u, r_u, quot, rem;

  // Divide works on magnitudes; signs are reapplied so the quotient truncates
  // toward zero and the remainder follows the dividend.
  always_comb begin
    prod_s  = $signed({{32{E_data1[31]}}, E_data1}) * $signed({{32{E_data2[31]}}, E_data2});
    prod_u  = {32'd0, E_data1} * {32'd0, E_data2};
    is_sdiv = (E_md_op == MD_DIV);
    a_neg   = is_sdiv && E_data1[31];
    b_neg   = is_sdiv && E_data2[31];
    abs_a   = a_neg ? -E_data1 : E_data1;
    abs_b   = b_neg ? -E_data2 : E_data2;
    divisor = (abs_b == 32'd0) ? 32'd1 : abs_b;
    q_u     = abs_a / divisor;
    r_u     = abs_a % divisor;
    quot    = (a_neg ^ b_neg) ? -q_u : q_u;
    rem     = a_neg ? -r_u : r_u;
  end

  always_comb begin
    // NOTE: every _d defaults to its _q first so no path leaves a value unassigned (no latches).
    state_d  = state_q;
    cnt_d    = cnt_q;
    hi_d     = hi_q;
    lo_d     = lo_q;
    hi_tmp_d = hi_tmp_q;
    lo_tmp_d = lo_tmp_q;
    dz_d     = dz_q;
    case (state_q)
      ST_IDLE: begin
        if (E_start) begin
          case (E_md_op)
            MD_MULT, MD_MULTU: begin
              hi_tmp_d = (E_md_op == MD_MULT) ? prod_s[63:32] : prod_u[63:32];
              lo_tmp_d = (E_md_op == MD_MULT) ? prod_s[31:0]  : prod_u[31:0];
              dz_d     = 1'b0;
              cnt_d    = CW'(MULT_CYCLES);
              state_d  = ST_RUN;
            end
            MD_DIV, MD_DIVU: begin
              hi_tmp_d = rem;
              lo_tmp_d = quot;
              dz_d     = (E_data2 == 32'd0);
              cnt_d    = CW'(DIV_CYCLES);
              state_d  = ST_RUN;
            end
            MD_MTHI: hi_d = E_data1;
            MD_MTLO: lo_d = E_data1;
            default: ;
          endcase
        end
      end
      ST_RUN: begin
        cnt_d = cnt_q - CW'(1);
        if (cnt_q == CW'(1)) begin
          state_d = ST_IDLE;
          if (!dz_q) begin
            hi_d = hi_tmp_q;
            lo_d = lo_tmp_q;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase
  end

  // NOTE: sequential state uses non-blocking assignments so all flops update together at the edge.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q  <= ST_IDLE;
      cnt_q    <= '0;
      hi_q     <= '0;
      lo_q     <= '0;
      hi_tmp_q <= '0;
      lo_tmp_q <= '0;
      dz_q     <= 1'b0;
    end else begin
      state_q  <= state_d;
      cnt_q    <= cnt_d;
      hi_q     <= hi_d;
      lo_q     <= lo_d;
      hi_tmp_q <= hi_tmp_d;
      lo_tmp_q <= lo_tmp_d;
      dz_q     <= dz_d;
    end
  end

  assign E_busy = (state_q == ST_RUN);
  assign E_HI   = hi_q;
  assign E_LO   = lo_q;

  // The hazard controller must stall D while busy; a start here is dropped.
  illegal_start_a : assert property (@(posedge clk) disable iff (!rst)
    !(state_q == ST_RUN && E_start && E_md_op inside {[MD_MULT:MD_MTLO]}))
    else $warning("e_mdu: E_start during RUN ignored");

endmodule

// File: doc/e_mdu.md
# e_mdu

Multiply/divide unit for the E stage of the five-stage MIPS pipeline, sitting beside the ALU and fed by the same forwarded operands. It executes mult, multu, div, divu as multi-cycle operations with a busy flag, executes mthi/mtlo in one cycle, and holds the architectural HI/LO registers that mfhi/mflo read back into the E-stage GRF write-data mux. The hazard controller uses its busy output to stall the D stage whenever an MD-class instruction would collide with an operation in flight.

## Interface
- MULT_CYCLES, 5, busy duration of mult/multu in cycles (>=1)
- DIV_CYCLES, 10, busy duration of div/divu in cycles (>=1)
- clk  in  1  pipeline clock, rising edge
- rst  in  1  reset, asynchronous, active-low
- E_md_op  in  3  0 none, 1 mult, 2 multu, 3 div, 4 divu, 5 mthi, 6 mtlo; 7 reserved = none
- E_start  in  1  qualifies E_md_op; high only for a real, non-bubble instruction in E
- E_data1  in  32  forwarded rs value
- E_data2  in  32  forwarded rt value
- E_busy  out  1  operation in flight
- E_HI  out  32  architectural HI
- E_LO  out  32  architectural LO

## Operation
- States: IDLE, RUN. Counter cnt, width $clog2(max(MULT_CYCLES,DIV_CYCLES))+1.
- IDLE, E_start with op 1-4: latch result into hi_tmp/lo_tmp, load cnt with MULT_CYCLES or DIV_CYCLES, go RUN.
  - mult: signed 32x32 -> 64; HI = [63:32], LO = [31:0].
  - multu: same, unsigned.
  - div: LO = signed quotient truncated toward zero, HI = remainder with dividend's sign.
  - divu: unsigned quotient/remainder.
  - div/divu with E_data2 == 0: unit goes busy for the full DIV_CYCLES; at completion HI/LO are left unchanged.
  - div 0x80000000 / 0xFFFFFFFF: LO = 0x80000000, HI = 0.
- IDLE, E_start with op 5/6: HI (mthi) or LO (mtlo) <= E_data1 at that edge. There is no busy period.
- IDLE, E_start with op 0/7, or E_start low: no state change.
- RUN: cnt decrements each edge. At the edge where cnt == 1, HI/LO <= hi_tmp/lo_tmp, unless this is a divide by zero, and the unit returns to IDLE.
- E_start in RUN is a protocol violation: it is ignored and flagged by a simulation-only assertion. The hazard controller guarantees it never happens by stalling D while (E_start && op in 1-6) || E_busy.
- E_busy = (state == RUN).
- Reset while asserted, at any time including mid-RUN: state IDLE, cnt 0, E_busy 0, E_HI 0, E_LO 0, hi_tmp/lo_tmp 0. The in-flight operation is lost.

## Timing
- Start sampled at edge t0 -> E_busy high for exactly N cycles (t0..t0+N). At edge t0+N, E_busy falls and the new HI/LO become visible in the same cycle.
- mthi/mtlo: new value visible the cycle after the sampling edge, so an mfhi in E one cycle later sees it.
- E_HI/E_LO are register outputs with no combinational path from inputs. mfhi/mflo read them directly in E.
- A back-to-back start is legal in the cycle E_busy falls (state IDLE).

## Structure
- Shared package mdu_pkg holds:
  - MD_NONE..MD_MTLO opcode constants
  - state enum
  - default MULT_CYCLES/DIV_CYCLES
- The E_controller decodes instructions into E_md_op using these constants.
- Single module, no sub-module. The arithmetic is behavioural * and / on sign-adjusted operands, computed at start. The cycle count models latency only.

## Test plan
- Signed mult: mult 0xFFFFFFFE x 0x00000003, start at t0 -> E_busy high t0..t0+5, then HI=0xFFFFFFFF, LO=0xFFFFFFFA; values unchanged before t0+5.
- Unsigned vs signed divide:
  - divu 0xFFFFFFF9 / 2 -> LO=0x7FFFFFFC, HI=1 after 10 busy cycles.
  - div 0xFFFFFFF9 / 2 -> LO=0xFFFFFFFD, HI=0xFFFFFFFF.
- Divide by zero: preload HI=0x11, LO=0x22 via mthi/mtlo; div x/0 -> busy 10 cycles, then HI=0x11, LO=0x22.
- mthi/mtlo timing: mthi 0xDEADBEEF -> E_HI=0xDEADBEEF next cycle, E_busy stays 0. An immediately following multu 2x3 starts cleanly -> HI=0, LO=6.
- Reset mid-operation: assert rst 3 cycles into a mult -> E_busy, E_HI, E_LO go to 0 asynchronously, before the next edge. After release, no completion write occurs.
- Back-to-back and illegal start:
  - A second mult started in the cycle E_busy falls completes correctly.
  - E_start pulsed during RUN is ignored and fires the assertion; the original result is unaffected.
